// File: rtl/tape_saver.sv
// Streams an Oric memory region as a .TAP image over the ioctl upload channel.
// The header is generated on the fly; payload bytes are fetched through an arbitrated RAM read port.
module tape_saver #(
  parameter int SYNC_LEN = 3
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic [15:0] save_start,
  input  logic [15:0] save_end,
  input  logic [7:0]  save_type,
  input  logic [7:0]  save_auto,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic        ram_gnt,
  input  logic [7:0]  ram_q,
  output logic [16:0] save_size,
  output logic        busy
);

  localparam logic [24:0] SYNC_W = 25'(SYNC_LEN);
  localparam logic [24:0] HDR_W  = 25'(SYNC_LEN + 11);

  typedef enum logic [1:0] {IDLE, READY, REQ, DATA} state_t;
  state_t state_reg, state_next;

  logic        upload_prev_reg;
  logic [15:0] start_reg;
  logic [15:0] end_reg;
  logic [7:0]  type_reg;
  logic [7:0]  auto_reg;
  logic [16:0] len_reg;
  logic [16:0] size_reg;
  logic [7:0]  din_reg;
  logic [15:0] addr_reg;

  logic        upload_rise;
  logic        upload_lost;
  logic [16:0] len_calc;
  logic [24:0] hdr_idx;
  logic [24:0] pay_off;
  logic        is_header;
  logic        is_payload;
  logic        rd_accept;
  logic [7:0]  hdr_byte;

  assign upload_rise = ioctl_upload & ~upload_prev_reg;
  assign upload_lost = (state_reg != IDLE) & ~ioctl_upload;
  assign len_calc    = (save_end >= save_start) ?
                       ({1'b0, save_end} - {1'b0, save_start} + 17'd1) : 17'd0;
  assign hdr_idx     = ioctl_addr - SYNC_W;
  assign pay_off     = ioctl_addr - HDR_W;
  assign is_header   = ioctl_addr < HDR_W;
  // pay_off < len is only meaningful past the header, where it cannot underflow
  assign is_payload  = !is_header && (pay_off < {8'd0, len_reg});
  assign rd_accept   = (state_reg == READY) && ioctl_rd && ioctl_upload;

  always_comb begin
    hdr_byte = 8'h00;
    if (ioctl_addr < SYNC_W) begin
      hdr_byte = 8'h16;
    end else begin
      case (hdr_idx)
        25'd0:   hdr_byte = 8'h24;
        25'd3:   hdr_byte = type_reg;
        25'd4:   hdr_byte = auto_reg;
        25'd5:   hdr_byte = end_reg[15:8];
        25'd6:   hdr_byte = end_reg[7:0];
        25'd7:   hdr_byte = start_reg[15:8];
        25'd8:   hdr_byte = start_reg[7:0];
        default: hdr_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (upload_rise) state_next = READY;
      READY:   if (ioctl_rd && is_payload) state_next = REQ;
      REQ:     if (ram_gnt) state_next = DATA;
      DATA:    state_next = READY;
      default: state_next = IDLE;
    endcase
    if (upload_lost) state_next = IDLE;
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    ram_rd     = (state_reg == REQ);
    ioctl_wait = (state_reg == REQ) || (state_reg == DATA);
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      upload_prev_reg <= 1'b0;
      start_reg       <= 16'h0000;
      end_reg         <= 16'h0000;
      type_reg        <= 8'h00;
      auto_reg        <= 8'h00;
      len_reg         <= 17'd0;
      size_reg        <= 17'd0;
      din_reg         <= 8'h00;
      addr_reg        <= 16'h0000;
    end else begin
      upload_prev_reg <= ioctl_upload;
      if (state_reg == IDLE && upload_rise) begin
        start_reg <= save_start;
        end_reg   <= save_end;
        type_reg  <= save_type;
        auto_reg  <= save_auto;
        len_reg   <= len_calc;
        size_reg  <= HDR_W[16:0] + len_calc;
      end
      if (rd_accept) begin
        if (is_payload)     addr_reg <= start_reg + pay_off[15:0];
        else if (is_header) din_reg  <= hdr_byte;
        else                din_reg  <= 8'h00;
      end
      // a fetch aborted by upload loss never lands in ioctl_din
      if (state_reg == DATA && state_next == READY) din_reg <= ram_q;
    end
  end

  assign ioctl_din = din_reg;
  assign ram_addr  = addr_reg;
  assign save_size = size_reg;

endmodule

// File: tb/tb_tape_saver.sv
// Scoreboard bench for tape_saver: a RAM/arbiter model answers fetches and
// every delivered byte is compared against a queue of expected values.
module tb_tape_saver;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic [15:0] save_start, save_end;
  logic [7:0]  save_type, save_auto;
  logic        ioctl_upload, ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] ram_addr;
  logic        ram_rd, ram_gnt;
  logic [7:0]  ram_q;
  logic [16:0] save_size;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int grant_cnt = 0;
  logic rd_seen = 1'b0;
  logic [7:0] mem [65536];
  logic [7:0] exp_q [$];

  tape_saver #(.SYNC_LEN(3)) dut (
    .clk_48(clk_48), .reset(reset),
    .save_start(save_start), .save_end(save_end),
    .save_type(save_type), .save_auto(save_auto),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_gnt(ram_gnt), .ram_q(ram_q),
    .save_size(save_size), .busy(busy)
  );

  always #5 clk_48 = ~clk_48;

  // RAM with one-cycle read latency behind the grant
  always @(posedge clk_48) begin
    if (ram_rd) rd_seen = 1'b1;
    if (ram_rd && ram_gnt) begin
      ram_q <= mem[ram_addr];
      grant_cnt = grant_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic open_session(input logic [15:0] s, input logic [15:0] e,
                              input logic [7:0] t, input logic [7:0] au,
                              input logic [16:0] exp_size, input string tag);
    @(negedge clk_48);
    save_start = s; save_end = e; save_type = t; save_auto = au;
    ioctl_upload = 1'b1;
    @(negedge clk_48);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_size"}, save_size, exp_size);
    $display("session %s start=%h end=%h size=%0d", tag, s, e, save_size);
  endtask

  task automatic close_session(input string tag);
    @(negedge clk_48);
    ioctl_upload = 1'b0;
    @(negedge clk_48);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Request one byte; the expected byte goes into the scoreboard at request time
  task automatic rd_byte(input int off, input logic [7:0] exp, input int exp_wait,
                         input string tag);
    int waits;
    logic [7:0] want;
    exp_q.push_back(exp);
    @(negedge clk_48);
    ioctl_rd = 1'b1; ioctl_addr = 25'(off);
    @(negedge clk_48);
    ioctl_rd = 1'b0;
    waits = 0;
    while (ioctl_wait && waits < 50) begin
      waits++;
      @(negedge clk_48);
    end
    want = exp_q.pop_front();
    $display("read %s off=%0d din=%h exp=%h wait=%0d", tag, off, ioctl_din, want, waits);
    chk({tag, "_wait"}, waits, exp_wait);
    chk({tag, "_din"}, ioctl_din, want);
  endtask

  initial begin
    int g0, waits;
    logic [15:0] a0;
    logic stable;
    logic [7:0] hdr [14];
    hdr = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'hC7,
            8'h05, 8'h03, 8'h05, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 65536; i++) mem[i] = pat(i);
    mem[16'h0500] = 8'hAA; mem[16'h0501] = 8'hBB;
    mem[16'h0502] = 8'hCC; mem[16'h0503] = 8'hDD;
    mem[16'hFFFF] = 8'h3C;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    save_start = '0; save_end = '0; save_type = '0; save_auto = '0;
    ram_gnt = 1'b1;
    repeat (3) @(negedge clk_48);
    chk("rst_din", ioctl_din, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_size", save_size, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Basic image: header then four payload bytes
    open_session(16'h0500, 16'h0503, 8'h80, 8'hC7, 17'd18, "basic");
    save_start = 16'h1234; save_end = 16'h0000; save_type = 8'h00;
    for (int i = 0; i < 14; i++) begin
      rd_seen = 1'b0;
      rd_byte(i, hdr[i], 0, $sformatf("hdr%0d", i));
      chk($sformatf("hdr%0d_noram", i), rd_seen, 0);
    end
    rd_byte(14, 8'hAA, 2, "pay14");
    rd_byte(15, 8'hBB, 2, "pay15");
    rd_byte(16, 8'hCC, 2, "pay16");
    rd_byte(17, 8'hDD, 2, "pay17");
    g0 = grant_cnt; rd_seen = 1'b0;
    rd_byte(18, 8'h00, 0, "oor18");
    chk("oor18_noram", rd_seen, 0);
    chk("oor18_gnt", grant_cnt, g0);

    // Grant withheld for 5 cycles
    ram_gnt = 1'b0;
    exp_q.push_back(8'hBB);
    @(negedge clk_48);
    ioctl_rd = 1'b1; ioctl_addr = 25'd15;
    @(negedge clk_48);
    ioctl_rd = 1'b0;
    a0 = ram_addr; stable = 1'b1; waits = 0;
    chk("hold_addr", a0, 16'h0501);
    while (ioctl_wait && waits < 50) begin
      waits++;
      if (waits <= 6 && (ram_rd !== 1'b1 || ram_addr !== a0)) stable = 1'b0;
      if (waits == 6) ram_gnt = 1'b1;
      @(negedge clk_48);
    end
    $display("read hold off=15 din=%h wait=%0d", ioctl_din, waits);
    chk("hold_stable", stable, 1);
    chk("hold_wait", waits, 7);
    chk("hold_din", ioctl_din, exp_q.pop_front());
    chk("hold_rd_drop", ram_rd, 0);
    close_session("basic");

    // end < start: empty payload
    open_session(16'hFFFE, 16'h0001, 8'h00, 8'h00, 17'd14, "empty");
    g0 = grant_cnt; rd_seen = 1'b0;
    rd_byte(14, 8'h00, 0, "empty14");
    chk("empty14_noram", rd_seen, 0);
    chk("empty14_gnt", grant_cnt, g0);
    close_session("empty");

    // Full 64 KB region
    open_session(16'h0000, 16'hFFFF, 8'h00, 8'h00, 17'd65550, "full");
    rd_byte(14, pat(0), 2, "full_first");
    rd_byte(65549, 8'h3C, 2, "full_last");
    rd_byte(65550, 8'h00, 0, "full_past");
    close_session("full");

    // Upload dropped while a fetch waits for grant
    ram_gnt = 1'b0;
    open_session(16'h0500, 16'h0503, 8'h80, 8'hC7, 17'd18, "drop");
    @(negedge clk_48);
    ioctl_rd = 1'b1; ioctl_addr = 25'd16;
    @(negedge clk_48);
    ioctl_rd = 1'b0;
    chk("drop_req_rd", ram_rd, 1);
    chk("drop_req_wait", ioctl_wait, 1);
    ioctl_upload = 1'b0;
    @(negedge clk_48);
    chk("drop_ram_rd", ram_rd, 0);
    chk("drop_wait", ioctl_wait, 0);
    chk("drop_busy", busy, 0);
    ram_gnt = 1'b1;

    // Reset while READY, then a fresh session with new parameters
    open_session(16'h1000, 16'h100F, 8'h80, 8'h00, 17'd30, "pre_rst");
    @(negedge clk_48);
    reset = 1'b1;
    @(negedge clk_48);
    chk("rst2_ram_rd", ram_rd, 0);
    chk("rst2_wait", ioctl_wait, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_size", save_size, 0);
    ioctl_upload = 1'b0;
    @(negedge clk_48);
    reset = 1'b0;
    open_session(16'h2000, 16'h2001, 8'h00, 8'h55, 17'd16, "post_rst");
    rd_byte(7, 8'h55, 0, "post_auto");
    rd_byte(10, 8'h20, 0, "post_start_hi");
    rd_byte(15, pat(16'h2001), 2, "post_pay");
    close_session("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tape_saver.md
# tape_saver

Tape-save counterpart of the cassette loader: on a host upload request it serialises an Oric memory region into a `.TAP` image and streams it to the host over the ioctl upload channel. It generates the tape header itself and fetches payload bytes through a shared, arbitrated read port on the 64 KB main RAM. It sits beside the loader in the top level, on the same `clk_48` domain, reading RAM instead of writing it.

## Interface
- `SYNC_LEN`, 3: number of 0x16 sync bytes at the start of the header (1..8).
- `clk_48`  in  1  system clock
- `reset`  in  1  synchronous reset, active-high
- `save_start`  in  16  first RAM address to save; sampled at upload start
- `save_end`  in  16  last RAM address, inclusive; sampled at upload start
- `save_type`  in  8  header type byte (0x00 BASIC, 0x80 machine code); sampled
- `save_auto`  in  8  header autorun byte; sampled
- `ioctl_upload`  in  1  host upload active (level)
- `ioctl_rd`  in  1  one-cycle byte request for `ioctl_addr`
- `ioctl_addr`  in  25  byte offset within the image
- `ioctl_din`  out  8  requested image byte
- `ioctl_wait`  out  1  high while a requested byte is not yet valid
- `ram_addr`  out  16  RAM read address
- `ram_rd`  out  1  RAM read request; held until granted
- `ram_gnt`  in  1  arbiter grant; the address is accepted in the cycle `ram_rd & ram_gnt`
- `ram_q`  in  8  RAM data, valid the cycle after grant
- `save_size`  out  17  total image length in bytes
- `busy`  out  1  upload session active

## Operation
- Header length `H = SYNC_LEN + 11`. Header bytes in order:
  - `SYNC_LEN` × 0x16
  - 0x24, 0x00, 0x00
  - type, auto
  - end_hi, end_lo, start_hi, start_lo
  - 0x00, 0x00 (unused byte, then empty-name terminator)
- Rising edge of `ioctl_upload` latches all `save_*` inputs and sets `busy`.
  - `len = end - start + 1` when `end >= start`, else 0.
  - `save_size = H + len` (17-bit, max `H + 65536`).
- Byte request at offset `a`:
  - `a < H`: header byte.
  - `H <= a < H + len`: `RAM[start + (a - H)]`, 16-bit wrap on the address.
  - `a >= H + len`: 0x00, no RAM access.
- States:
  - IDLE: `busy = 0`.
  - READY: session open, no request outstanding.
  - REQ: `ram_rd` asserted, waiting for grant.
  - DATA: capture `ram_q`.
- Transitions:
  - IDLE -> READY on the `ioctl_upload` rise.
  - READY -> REQ on a payload request.
  - REQ -> DATA on grant.
  - DATA -> READY.
  - Any state -> IDLE on the `ioctl_upload` fall or on `reset`.
- Header and out-of-range requests are served from READY without changing state.
- `ioctl_rd` while REQ or DATA: protocol violation, ignored. Verification flags it.
- `ioctl_upload` falling mid-fetch: drop `ram_rd` next cycle, discard the data, deassert `ioctl_wait`, go to IDLE.
- `save_*` changes during a session have no effect.

## Timing
- Reset values:
  - `ioctl_din = 0x00`, `ioctl_wait = 0`, `ram_rd = 0`, `ram_addr = 0x0000`, `save_size = 0`, `busy = 0`, state IDLE.
- `busy` rises the cycle after `ioctl_upload` is first seen high.
- `save_size` is valid in that same cycle and holds until the next session.
- Header or out-of-range request with `ioctl_rd` at cycle T:
  - `ioctl_din` valid at T+1.
  - `ioctl_wait` stays 0.
- Payload request with `ioctl_rd` at cycle T:
  - T+1: `ioctl_wait = 1`, `ram_rd = 1`, `ram_addr` valid.
  - Grant at cycle G (G >= T+1).
  - G+1: capture `ram_q` into `ioctl_din`.
  - G+2: `ioctl_wait = 0`, `ioctl_din` valid.
  - Minimum latency is 2 cycles of wait.
- `ram_rd` and `ram_addr` stay stable until granted and drop the cycle after grant.
- Offset arithmetic is 25-bit; the RAM address is the low 16 bits of `start + (a - H)`.

## Test plan
- `SYNC_LEN = 3`, start 0x0500, end 0x0503, type 0x80, auto 0xC7:
  - `save_size = 18`.
  - Offsets 0..13 read 16 16 16 24 00 00 80 C7 05 03 05 00 00 00.
- Same setup, RAM 0x0500..0x0503 = AA BB CC DD:
  - Offsets 14..17 read AA BB CC DD.
  - Each has `ioctl_wait` high exactly 2 cycles with `ram_gnt` tied high.
  - Offset 18 reads 0x00 with no `ram_rd`.
- `ram_gnt` held low 5 cycles on a payload request:
  - `ram_rd` and `ram_addr` stable throughout.
  - `ioctl_wait` high for 7 cycles.
  - Correct byte delivered.
- start 0xFFFE, end 0x0001 (end < start):
  - `save_size = 14`.
  - Offset 14 returns 0x00 without a RAM access.
- start 0x0000, end 0xFFFF:
  - `save_size = 65550`.
  - Last offset 65549 reads `RAM[0xFFFF]`.
- Drop `ioctl_upload` while in REQ, then assert `reset` while READY:
  - Each time, by the next cycle `ram_rd = 0`, `ioctl_wait = 0`, `busy = 0`.
  - A new session re-samples the `save_*` inputs.
